// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: control-word bit positions and
// the EX operand forwarding select encoding.
package cpu_pkg;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// EX operand source select for one operand; purely combinational.
// MEM result wins over WB data; a load sitting in MEM is never a source.
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_wr,
  input  logic                  wb_wr,
  input  logic                  mem_read,
  output logic [1:0]            sel
);

  fwd_sel_e sel_e;

  always_comb begin
    sel_e = FWD_REG;
    if (mem_wr && (mem_rd == ex_rs) && !mem_read) begin
      sel_e = FWD_MEM;
    end else if (wb_wr && (wb_rd == ex_rs)) begin
      sel_e = FWD_WB;
    end
  end

  assign sel = sel_e;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage core: carries control words ID->EX->MEM->WB
// (3 cycles), stalls IF/ID on unresolved RAW hazards by injecting EX bubbles.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [CTRL_W-1:0]     id_ctrl_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  id_branch_i,
  input  logic                  branch_taken_i,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic [CTRL_W-1:0]     ex_ctrl_o,
  output logic [CTRL_W-1:0]     mem_ctrl_o,
  output logic [CTRL_W-1:0]     wb_ctrl_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [REG_ADDR_W-1:0] mem_rd_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic                  ex_valid_o,
  output logic                  mem_valid_o,
  output logic                  wb_valid_o,
  output logic                  wb_reg_write_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o
);

  logic                  ex_valid, mem_valid, wb_valid;
  logic [CTRL_W-1:0]     ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2;

  logic wr_ex, wr_mem, wr_wb;
  logic match_ex, match_mem;
  logic stall_raw, stall, flush, id_adv;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic src_match(input logic [REG_ADDR_W-1:0] rd);
    return (id_uses_rs1_i && (id_rs1_i == rd)) ||
           (id_uses_rs2_i && (id_rs2_i == rd));
  endfunction

  // x0 is hard-wired: a stage targeting it is never a producer
  assign wr_ex  = ex_valid  & ex_ctrl[CTRL_REG_WRITE]  & (ex_rd  != '0);
  assign wr_mem = mem_valid & mem_ctrl[CTRL_REG_WRITE] & (mem_rd != '0);
  assign wr_wb  = wb_valid  & wb_ctrl[CTRL_REG_WRITE]  & (wb_rd  != '0);

  assign match_ex  = wr_ex  & src_match(ex_rd);
  assign match_mem = wr_mem & src_match(mem_rd);

  always_comb begin
    stall_raw = 1'b0;
    if (FWD_EN) begin
      // branches compare in ID, so they also wait on ALU results still in EX
      stall_raw = (match_ex & ex_ctrl[CTRL_MEM_READ]) |
                  (id_branch_i & match_ex) |
                  (id_branch_i & match_mem & mem_ctrl[CTRL_MEM_READ]);
    end else begin
      stall_raw = match_ex | match_mem;
    end
  end

  assign stall  = id_valid_i & stall_raw;
  assign flush  = id_valid_i & id_branch_i & branch_taken_i & ~stall;
  assign id_adv = id_valid_i & ~stall & ~flush;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rd     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
      wb_rd     <= '0;
    end else begin
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl;
      wb_rd     <= mem_rd;
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl;
      mem_rd    <= ex_rd;
      if (id_adv) begin
        ex_valid <= 1'b1;
        ex_ctrl  <= id_ctrl_i;
        ex_rd    <= id_rd_i;
        ex_rs1   <= id_rs1_i;
        ex_rs2   <= id_rs2_i;
      end else begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rd    <= '0;
        ex_rs1   <= '0;
        ex_rs2   <= '0;
      end
    end
  end

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs    (ex_rs1),
    .mem_rd   (mem_rd),
    .wb_rd    (wb_rd),
    .mem_wr   (wr_mem),
    .wb_wr    (wr_wb),
    .mem_read (mem_ctrl[CTRL_MEM_READ]),
    .sel      (fwd_a)
  );

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs    (ex_rs2),
    .mem_rd   (mem_rd),
    .wb_rd    (wb_rd),
    .mem_wr   (wr_mem),
    .wb_wr    (wr_wb),
    .mem_read (mem_ctrl[CTRL_MEM_READ]),
    .sel      (fwd_b)
  );

  assign fwd_a_sel_o = (FWD_EN && ex_valid) ? fwd_a : 2'b00;
  assign fwd_b_sel_o = (FWD_EN && ex_valid) ? fwd_b : 2'b00;

  assign stall_o        = stall;
  assign flush_o        = flush;
  assign ex_ctrl_o      = ex_ctrl;
  assign mem_ctrl_o     = mem_ctrl;
  assign wb_ctrl_o      = wb_ctrl;
  assign ex_rd_o        = ex_rd;
  assign mem_rd_o       = mem_rd;
  assign wb_rd_o        = wb_rd;
  assign ex_valid_o     = ex_valid;
  assign mem_valid_o    = mem_valid;
  assign wb_valid_o     = wb_valid;
  assign wb_reg_write_o = wb_valid & wb_ctrl[CTRL_REG_WRITE];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: one instance with forwarding, one without,
// both checked every cycle against a stage-readiness model.
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] ALU = 8'hA1;
  localparam logic [7:0] LD  = 8'h0B;
  localparam logic [7:0] ST  = 8'h44;
  localparam logic [7:0] BR  = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_branch, branch_taken;
  logic [7:0] id_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic       d1_stall, d1_flush, d1_exv, d1_memv, d1_wbv, d1_wbrw;
  logic [7:0] d1_exc, d1_memc, d1_wbc;
  logic [4:0] d1_exr, d1_memr, d1_wbr;
  logic [1:0] d1_fa, d1_fb;
  logic       d0_stall, d0_flush, d0_exv, d0_memv, d0_wbv, d0_wbrw;
  logic [7:0] d0_exc, d0_memc, d0_wbc;
  logic [4:0] d0_exr, d0_memr, d0_wbr;
  logic [1:0] d0_fa, d0_fb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CTRL_W(8), .FWD_EN(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
    .id_branch_i(id_branch), .branch_taken_i(branch_taken),
    .stall_o(d1_stall), .flush_o(d1_flush),
    .ex_ctrl_o(d1_exc), .mem_ctrl_o(d1_memc), .wb_ctrl_o(d1_wbc),
    .ex_rd_o(d1_exr), .mem_rd_o(d1_memr), .wb_rd_o(d1_wbr),
    .ex_valid_o(d1_exv), .mem_valid_o(d1_memv), .wb_valid_o(d1_wbv),
    .wb_reg_write_o(d1_wbrw), .fwd_a_sel_o(d1_fa), .fwd_b_sel_o(d1_fb));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CTRL_W(8), .FWD_EN(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
    .id_branch_i(id_branch), .branch_taken_i(branch_taken),
    .stall_o(d0_stall), .flush_o(d0_flush),
    .ex_ctrl_o(d0_exc), .mem_ctrl_o(d0_memc), .wb_ctrl_o(d0_wbc),
    .ex_rd_o(d0_exr), .mem_rd_o(d0_memr), .wb_rd_o(d0_wbr),
    .ex_valid_o(d0_exv), .mem_valid_o(d0_memv), .wb_valid_o(d0_wbv),
    .wb_reg_write_o(d0_wbrw), .fwd_a_sel_o(d0_fa), .fwd_b_sel_o(d0_fb));

  // ---------------- model ----------------
  typedef struct packed {
    logic       v;
    logic [7:0] ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_t;
  typedef instr_t [2:0] pipe_t;  // [0]=EX [1]=MEM [2]=WB

  pipe_t m1, m0;
  bit    started = 1'b0;

  function automatic logic reads_reg(input logic [4:0] r);
    return (id_uses_rs1 && id_rs1 == r) || (id_uses_rs2 && id_rs2 == r);
  endfunction

  function automatic logic writes(input instr_t i);
    return i.v && i.ctrl[0] && (i.rd != 5'd0);
  endfunction

  // Earliest pipe position (1=EX,2=MEM,3=WB) at which the producer's value
  // is usable by the instruction now in ID.
  function automatic int ready_pos(input instr_t i, input bit fwd);
    if (!fwd) return 3;
    if (id_branch) return i.ctrl[1] ? 3 : 2;
    return i.ctrl[1] ? 2 : 1;
  endfunction

  function automatic logic m_stall(input pipe_t p, input bit fwd);
    if (!id_valid) return 1'b0;
    for (int k = 0; k < 3; k++)
      if (writes(p[k]) && reads_reg(p[k].rd) && (k + 1 < ready_pos(p[k], fwd)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_flush(input pipe_t p, input bit fwd);
    return id_valid && id_branch && branch_taken && !m_stall(p, fwd);
  endfunction

  function automatic logic [1:0] m_fwd(input pipe_t p, input bit fwd, input bit b);
    logic [4:0] rs;
    if (!fwd || !p[0].v) return 2'd0;
    rs = b ? p[0].rs2 : p[0].rs1;
    if (writes(p[1]) && p[1].rd == rs && !p[1].ctrl[1]) return 2'd1;
    if (writes(p[2]) && p[2].rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic pipe_t m_next(input pipe_t p, input bit fwd);
    instr_t n;
    n = '0;
    if (id_valid && !m_stall(p, fwd) && !m_flush(p, fwd)) begin
      n.v = 1'b1; n.ctrl = id_ctrl; n.rd = id_rd; n.rs1 = id_rs1; n.rs2 = id_rs2;
    end
    return {p[1], p[0], n};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m1 <= '0;
      m0 <= '0;
      started <= 1'b1;
    end else begin
      m1 <= m_next(m1, 1'b1);
      m0 <= m_next(m0, 1'b0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string t, input pipe_t p, input bit fwd,
                     input logic st, fl, input logic [1:0] fa, fb,
                     input logic [7:0] ec, mc, wc, input logic [4:0] er, mr, wr,
                     input logic ev, mv, wv, wrw);
    chk({t, ".stall"}, st, m_stall(p, fwd));
    chk({t, ".flush"}, fl, m_flush(p, fwd));
    chk({t, ".fwd_a"}, fa, m_fwd(p, fwd, 1'b0));
    chk({t, ".fwd_b"}, fb, m_fwd(p, fwd, 1'b1));
    chk({t, ".ex_valid"}, ev, p[0].v);
    chk({t, ".mem_valid"}, mv, p[1].v);
    chk({t, ".wb_valid"}, wv, p[2].v);
    chk({t, ".ex_ctrl"}, ec, p[0].ctrl);
    chk({t, ".mem_ctrl"}, mc, p[1].ctrl);
    chk({t, ".wb_ctrl"}, wc, p[2].ctrl);
    chk({t, ".ex_rd"}, er, p[0].rd);
    chk({t, ".mem_rd"}, mr, p[1].rd);
    chk({t, ".wb_rd"}, wr, p[2].rd);
    chk({t, ".wb_reg_write"}, wrw, p[2].v & p[2].ctrl[0]);
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("fwd1", m1, 1'b1, d1_stall, d1_flush, d1_fa, d1_fb, d1_exc, d1_memc, d1_wbc,
          d1_exr, d1_memr, d1_wbr, d1_exv, d1_memv, d1_wbv, d1_wbrw);
      cmp("fwd0", m0, 1'b0, d0_stall, d0_flush, d0_fa, d0_fb, d0_exc, d0_memc, d0_wbc,
          d0_exr, d0_memr, d0_wbr, d0_exv, d0_memv, d0_wbv, d0_wbrw);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_id(input logic v, input logic [7:0] c, input logic [4:0] rd, r1, r2,
                        input logic u1, u2, br, tk);
    id_valid = v; id_ctrl = c; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_branch = br; branch_taken = tk;
  endtask

  task automatic idle();
    set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
    chk({"lit.", n}, a, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) tick();
    @(negedge clk);
    lit("rst.stall", d1_stall, 1'b0);
    lit("rst.ex_valid", d1_exv, 1'b0);
    lit("rst.wb_reg_write", d1_wbrw, 1'b0);
    lit("rst.fwd0_mem_valid", d0_memv, 1'b0);
    rst_n = 1'b1;
    tick();

    // load then use
    set_id(1'b1, LD, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_id(1'b1, ALU, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); lit("lu.stall", d1_stall, 1'b1); lit("lu.ex_valid_ld", d1_exv, 1'b1);
    tick();
    @(negedge clk); lit("lu.bubble", d1_exv, 1'b0); lit("lu.stall_end", d1_stall, 1'b0);
    tick();
    idle();
    @(negedge clk); lit("lu.fwd_a", d1_fa, 2'b10); lit("lu.ex_rd", d1_exr, 5'd6);
    lit("lu.wb_rd", d1_wbr, 5'd5); lit("lu.wb_rw", d1_wbrw, 1'b1);
    tick();
    drain();

    // back-to-back ALU, MEM priority
    set_id(1'b1, ALU, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_id(1'b1, ALU, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_id(1'b1, ALU, 5'd9, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); lit("b2b.stall", d1_stall, 1'b0);
    tick();
    idle();
    @(negedge clk); lit("b2b.fwd_a", d1_fa, 2'b01); lit("b2b.fwd_b", d1_fb, 2'b01);
    tick();
    drain();

    // x0 destination
    set_id(1'b1, ALU, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_id(1'b1, LD, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_id(1'b1, ALU, 5'd10, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); lit("x0.stall", d1_stall, 1'b0); lit("x0.stall_nofwd", d0_stall, 1'b0);
    tick();
    idle();
    @(negedge clk); lit("x0.ex_valid", d1_exv, 1'b1);
    lit("x0.fwd_a", d1_fa, 2'b00); lit("x0.fwd_b", d1_fb, 2'b00);
    tick();
    drain();

    // store has no destination: no hazard
    set_id(1'b1, ST, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_id(1'b1, ALU, 5'd9, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); lit("st.stall", d1_stall, 1'b0); lit("st.stall_nofwd", d0_stall, 1'b0);
    tick();
    drain();

    // taken branch on a loaded register
    set_id(1'b1, LD, 5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_id(1'b1, BR, 5'd0, 5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk); lit("brld.stall1", d1_stall, 1'b1); lit("brld.flush1", d1_flush, 1'b0);
    tick();
    @(negedge clk); lit("brld.stall2", d1_stall, 1'b1); lit("brld.flush2", d1_flush, 1'b0);
    tick();
    @(negedge clk); lit("brld.stall3", d1_stall, 1'b0); lit("brld.flush3", d1_flush, 1'b1);
    tick();
    idle();
    @(negedge clk); lit("brld.flush4", d1_flush, 1'b0); lit("brld.ex_valid", d1_exv, 1'b0);
    tick();
    drain();

    // not-taken branch on an ALU result still in EX
    set_id(1'b1, ALU, 5'd12, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_id(1'b1, BR, 5'd0, 5'd12, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk); lit("bralu.stall", d1_stall, 1'b1);
    tick();
    @(negedge clk); lit("bralu.stall_end", d1_stall, 1'b0); lit("bralu.flush", d1_flush, 1'b0);
    tick();
    drain();

    // no forwarding: RAW waits until the producer reaches WB
    set_id(1'b1, ALU, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_id(1'b1, ALU, 5'd11, 5'd4, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); lit("nf.stall1", d0_stall, 1'b1);
    tick();
    @(negedge clk); lit("nf.stall2", d0_stall, 1'b1);
    tick();
    @(negedge clk); lit("nf.stall3", d0_stall, 1'b0); lit("nf.wb_rd", d0_wbr, 5'd4);
    lit("nf.wb_rw", d0_wbrw, 1'b1); lit("nf.ex_valid", d0_exv, 1'b0);
    tick();
    idle();
    @(negedge clk); lit("nf.ex_rd", d0_exr, 5'd11); lit("nf.fwd_a", d0_fa, 2'b00);
    tick();
    drain();

    // reset in the middle of a load-use stall
    set_id(1'b1, LD, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_id(1'b1, ALU, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); lit("rs.stall", d1_stall, 1'b1);
    rst_n = 1'b0;
    tick();
    @(negedge clk); lit("rs.ex_valid", d1_exv, 1'b0); lit("rs.mem_valid", d1_memv, 1'b0);
    lit("rs.wb_valid", d1_wbv, 1'b0); lit("rs.stall_after", d1_stall, 1'b0);
    lit("rs.wb_rw", d1_wbrw, 1'b0);
    rst_n = 1'b1;
    tick();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
